// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial unsigned A-B controller driving one NAND-built 1-bit full subtractor.
// Operands shift LSB-first through the cell; the borrow lives in a flop between cycles.
module sub_cell_nand (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bo
);
    logic w_n1, w_p, w_n2, w_nx, w_np, w_g, w_h;
    assign w_n1 = ~(i_x & i_y);
    assign w_p  = ~(~(i_x & w_n1) & ~(i_y & w_n1));
    assign w_n2 = ~(w_p & i_bin);
    assign o_d  = ~(~(w_p & w_n2) & ~(i_bin & w_n2));
    assign w_nx = ~(i_x & i_x);
    assign w_np = ~(w_p & w_p);
    // w_g low when ~x&y, w_h low when ~(x^y)&bin; their NAND is the borrow out
    assign w_g  = ~(w_nx & i_y);
    assign w_h  = ~(w_np & i_bin);
    assign o_bo = ~(w_g & w_h);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_sa, r_sb, r_res, r_diff, w_res_next;
    logic [CW-1:0] r_count;
    logic r_borrow, r_bout, w_d, w_bo, w_last;

    sub_cell_nand u_cell (
        .i_x  (r_sa[0]),
        .i_y  (r_sb[0]),
        .i_bin(r_borrow),
        .o_d  (w_d),
        .o_bo (w_bo)
    );

    assign w_last     = r_count == CW'(WIDTH - 1);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    assign o_diff     = r_diff;
    assign o_bout     = r_bout;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE && i_start) w_next = S_RUN;
        else if (r_state == S_RUN && w_last) w_next = S_DONE;
        else if (r_state == S_DONE) w_next = S_IDLE;
    end

    always_comb begin
        o_ready = r_state == S_IDLE;
        o_busy  = r_state != S_IDLE;
        o_done  = r_state == S_DONE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_count  <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_sa     <= i_a;
            r_sb     <= i_b;
            r_count  <= '0;
            r_borrow <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_sa     <= r_sa >> 1;
            r_sb     <= r_sb >> 1;
            r_res    <= w_res_next;
            r_borrow <= w_bo;
            r_count  <= r_count + CW'(1);
            if (w_last) begin
                r_diff <= w_res_next;
                r_bout <= w_bo;
            end
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: randomized and directed checks of serial_sub_ctrl against plain a-b arithmetic.
module tb_serial_sub_ctrl;
    localparam int W = 8;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start4 = 1'b0;
    logic [W-1:0] a = '0, b = '0, diff;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    logic ready, busy, done, bout, ready4, busy4, done4, bout4;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
        .o_ready(ready), .o_busy(busy), .o_done(done), .o_diff(diff), .o_bout(bout)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_a(a4), .i_b(b4),
        .o_ready(ready4), .o_busy(busy4), .o_done(done4), .o_diff(diff4), .o_bout(bout4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (!ready) begin
            fails++;
            $display("FAIL wait_ready: ready=%0b required 1 within 20 cycles", ready);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input string name);
        logic [W:0] ref_full;
        ref_full = {1'b0, ta} - {1'b0, tb_};
        wait_ready();
        a = ta;
        b = tb_;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= W + 1; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            tick();
            tests++;
            if (done !== (n == W)) begin
                fails++;
                $display("FAIL %s done_t%0d: done=%0b required %0b", name, n, done, n == W);
            end
            if (n == W) begin
                tests++;
                if (diff !== ref_full[W-1:0] || bout !== ref_full[W]) begin
                    fails++;
                    $display("FAIL %s result: diff=%h bout=%0b required diff=%h bout=%0b",
                             name, diff, bout, ref_full[W-1:0], ref_full[W]);
                end
            end
        end
        tests++;
        if (ready !== 1'b1 || diff !== ref_full[W-1:0] || bout !== ref_full[W]) begin
            fails++;
            $display("FAIL %s hold: ready=%0b diff=%h bout=%0b required 1 %h %0b",
                     name, ready, diff, bout, ref_full[W-1:0], ref_full[W]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'hAA;
        b = 8'h01;
        tick();
        tests++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            fails++;
            $display("FAIL reset: ready=%0b busy=%0b done=%0b diff=%h bout=%0b required 1 0 0 00 0",
                     ready, busy, done, diff, bout);
        end
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        tests++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_start_dropped: ready=%0b busy=%0b required 1 0", ready, busy);
        end
    endtask

    task automatic test_directed();
        run_op(8'h35, 8'h12, "basic");
        run_op(8'h12, 8'h35, "negative");
        run_op(8'h00, 8'h01, "ripple");
        run_op(8'hFF, 8'hFF, "equal");
        run_op(8'h80, 8'h7F, "msb");
        run_op(8'h00, 8'h00, "zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) run_op(W'($urandom), W'($urandom), "random");
    endtask

    task automatic test_back_to_back();
        wait_ready();
        start = 1'b1;
        a = 8'h10;
        b = 8'h01;
        tick();
        for (int op = 0; op < 3; op++) begin
            for (int n = 1; n <= W + 2; n++) begin
                if (n <= W) begin
                    a = W'($urandom);
                    b = W'($urandom);
                end else begin
                    a = 8'h10;
                    b = 8'h01;
                end
                tick();
                if (n <= W + 1) begin
                    tests++;
                    if (done !== (n == W) || ready !== (n == W + 1)) begin
                        fails++;
                        $display("FAIL b2b op%0d t%0d: done=%0b ready=%0b required %0b %0b",
                                 op, n, done, ready, n == W, n == W + 1);
                    end
                end
                if (n == W) begin
                    tests++;
                    if (diff !== 8'h0F || bout !== 1'b0) begin
                        fails++;
                        $display("FAIL b2b op%0d result: diff=%h bout=%0b required 0f 0",
                                 op, diff, bout);
                    end
                end
            end
        end
        start = 1'b0;
        for (int n = 0; n < W + 2; n++) tick();
    endtask

    task automatic test_mid_reset();
        wait_ready();
        a = 8'h5A;
        b = 8'h21;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++;
        if (ready !== 1'b1 || diff !== '0 || bout !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: ready=%0b diff=%h bout=%0b done=%0b required 1 00 0 0",
                     ready, diff, bout, done);
        end
        for (int n = 0; n < W + 2; n++) begin
            tick();
            tests++;
            if (done !== 1'b0 || diff !== '0) begin
                fails++;
                $display("FAIL mid_reset_quiet t%0d: done=%0b diff=%h required 0 00", n, done, diff);
            end
        end
        run_op(8'h5A, 8'h21, "after_reset");
    endtask

    task automatic test_exhaustive4();
        int bad = 0;
        logic [4:0] ref_full;
        for (int i = 0; i < 256; i++) begin
            a4 = 4'(i >> 4);
            b4 = 4'(i);
            ref_full = {1'b0, a4} - {1'b0, b4};
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            for (int n = 0; n < 4; n++) tick();
            tests++;
            if (done4 !== 1'b1 || diff4 !== ref_full[3:0] || bout4 !== ref_full[4]) begin
                fails++;
                bad++;
                if (bad <= 8)
                    $display("FAIL w4 a=%h b=%h: done=%0b diff=%h bout=%0b required 1 %h %0b",
                             a4, b4, done4, diff4, bout4, ref_full[3:0], ref_full[4]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_mid_reset();
        test_exhaustive4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
